// File: rtl/counter_cluster_param.sv
// -----------------------------------------------------------------------------
// counter_cluster_param
//   Bank of N_CH independent up/down counters, WIDTH bits each, sharing one
//   clock and one asynchronous active-low reset. Every channel supports enable,
//   direction, synchronous clear, parallel load and a programmable terminal
//   value. At the terminal value a channel either wraps or saturates
//   (SAT_MODE), raises a one-cycle registered terminal-count pulse and sets a
//   sticky overflow flag.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset (clears count, tc, ovf)
//   en_i         per-channel count enable
//   dir_i        per-channel direction, 1 = up, 0 = down
//   clr_i        per-channel synchronous clear (highest priority)
//   load_i       per-channel synchronous parallel load
//   load_val_i   load values, channel k at [k*WIDTH +: WIDTH]
//   term_val_i   terminal values, same packing
//   ovf_clr_i    clears all sticky overflow flags (a same-cycle set wins)
//   count_o      registered counter values, same packing
//   tc_o         registered terminal-count pulse per channel
//   ovf_o        sticky overflow flag per channel
//   any_tc_o     OR of tc_o
// -----------------------------------------------------------------------------
module counter_cluster_param #(
  parameter int N_CH     = 4,
  parameter int WIDTH    = 16,
  parameter int SAT_MODE = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [N_CH-1:0]       en_i,
  input  logic [N_CH-1:0]       dir_i,
  input  logic [N_CH-1:0]       clr_i,
  input  logic [N_CH-1:0]       load_i,
  input  logic [N_CH*WIDTH-1:0] load_val_i,
  input  logic [N_CH*WIDTH-1:0] term_val_i,
  input  logic                  ovf_clr_i,
  output logic [N_CH*WIDTH-1:0] count_o,
  output logic [N_CH-1:0]       tc_o,
  output logic [N_CH-1:0]       ovf_o,
  output logic                  any_tc_o
);

  localparam bit SAT = (SAT_MODE != 0);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [WIDTH-1:0] cnt_q, cnt_d;
      logic             tc_q, tc_d;
      logic             ovf_q, ovf_d;
      logic             term_evt;
      logic [WIDTH-1:0] load_v;
      logic [WIDTH-1:0] term_v;

      assign load_v = load_val_i[gi*WIDTH +: WIDTH];
      assign term_v = term_val_i[gi*WIDTH +: WIDTH];

      always_comb begin
        cnt_d    = cnt_q;
        term_evt = 1'b0;
        if (clr_i[gi]) begin
          cnt_d = '0;
        end else if (load_i[gi]) begin
          cnt_d = load_v;
        end else if (en_i[gi]) begin
          if (dir_i[gi]) begin
            // >= so that a count loaded above the terminal value still
            // terminates on the next enabled edge instead of running on.
            if (cnt_q >= term_v) begin
              term_evt = 1'b1;
              cnt_d    = SAT ? cnt_q : '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            if (cnt_q == '0) begin
              term_evt = 1'b1;
              cnt_d    = SAT ? '0 : term_v;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        tc_d = term_evt;
        // A terminal event in the same cycle as ovf_clr keeps the flag set.
        if (term_evt) begin
          ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
          ovf_d = 1'b0;
        end else begin
          ovf_d = ovf_q;
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cnt_q <= '0;
          tc_q  <= 1'b0;
          ovf_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          tc_q  <= tc_d;
          ovf_q <= ovf_d;
        end
      end

      assign count_o[gi*WIDTH +: WIDTH] = cnt_q;
      assign tc_o[gi]                   = tc_q;
      assign ovf_o[gi]                  = ovf_q;
    end
  endgenerate

  assign any_tc_o = |tc_o;

endmodule

// File: tb/tb_counter_cluster_param.sv
module tb_counter_cluster_param;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int BW = N * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  en, dir, clr, load;
  logic [BW-1:0] load_val, term_val;
  logic          ovf_clr;

  // Two instances on identical stimulus: wrap (index 0) and saturate (index 1).
  logic [BW-1:0] cnt_w, cnt_s;
  logic [N-1:0]  tc_w, tc_s, ovf_w, ovf_s;
  logic          any_w, any_s;

  counter_cluster_param #(.N_CH(N), .WIDTH(W), .SAT_MODE(0)) dut_wrap (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .dir_i(dir), .clr_i(clr),
    .load_i(load), .load_val_i(load_val), .term_val_i(term_val),
    .ovf_clr_i(ovf_clr), .count_o(cnt_w), .tc_o(tc_w), .ovf_o(ovf_w),
    .any_tc_o(any_w));

  counter_cluster_param #(.N_CH(N), .WIDTH(W), .SAT_MODE(1)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .dir_i(dir), .clr_i(clr),
    .load_i(load), .load_val_i(load_val), .term_val_i(term_val),
    .ovf_clr_i(ovf_clr), .count_o(cnt_s), .tc_o(tc_s), .ovf_o(ovf_s),
    .any_tc_o(any_s));

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- behavioural reference model ----------------
  int unsigned m_cnt [2][N];
  bit          m_tc  [2][N];
  bit          m_ovf [2][N];

  task automatic model_reset();
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < N; k++) begin
        m_cnt[s][k] = 0; m_tc[s][k] = 0; m_ovf[s][k] = 0;
      end
  endtask

  // Next state from the rules: clr > load > en > hold; up terminal at
  // count >= term, down terminal at 0; wrap vs hold chosen by mode s.
  task automatic model_step();
    int unsigned tv, lv;
    bit term;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < N; k++) begin
        tv   = int'(term_val[k*W +: W]);
        lv   = int'(load_val[k*W +: W]);
        term = 0;
        if (clr[k])       m_cnt[s][k] = 0;
        else if (load[k]) m_cnt[s][k] = lv;
        else if (en[k]) begin
          if (dir[k]) begin
            if (m_cnt[s][k] >= tv) begin
              term = 1;
              if (s == 0) m_cnt[s][k] = 0;
            end else m_cnt[s][k] = (m_cnt[s][k] + 1) % (1 << W);
          end else begin
            if (m_cnt[s][k] == 0) begin
              term = 1;
              if (s == 0) m_cnt[s][k] = tv;
            end else m_cnt[s][k] = m_cnt[s][k] - 1;
          end
        end
        m_tc[s][k] = term;
        if (term)         m_ovf[s][k] = 1;
        else if (ovf_clr) m_ovf[s][k] = 0;
      end
  endtask

  function automatic logic [63:0] m_cnt_bus(int s);
    logic [63:0] b = '0;
    for (int k = 0; k < N; k++) b[k*W +: W] = m_cnt[s][k][W-1:0];
    return b;
  endfunction

  function automatic logic [63:0] m_bits(int s, bit want_ovf);
    logic [63:0] b = '0;
    for (int k = 0; k < N; k++) b[k] = want_ovf ? m_ovf[s][k] : m_tc[s][k];
    return b;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_cnt_wrap"}, 64'(cnt_w), m_cnt_bus(0));
    chk({tag, "_cnt_sat"},  64'(cnt_s), m_cnt_bus(1));
    chk({tag, "_tc_wrap"},  64'(tc_w),  m_bits(0, 0));
    chk({tag, "_tc_sat"},   64'(tc_s),  m_bits(1, 0));
    chk({tag, "_ovf_wrap"}, 64'(ovf_w), m_bits(0, 1));
    chk({tag, "_ovf_sat"},  64'(ovf_s), m_bits(1, 1));
    chk({tag, "_any_wrap"}, 64'(any_w), 64'(|m_bits(0, 0)));
    chk({tag, "_any_sat"},  64'(any_s), 64'(|m_bits(1, 0)));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cnt_wrap"}, 64'(cnt_w), 64'd0);
    chk({tag, "_cnt_sat"},  64'(cnt_s), 64'd0);
    chk({tag, "_tc"},       64'({tc_w, tc_s}), 64'd0);
    chk({tag, "_ovf"},      64'({ovf_w, ovf_s}), 64'd0);
    chk({tag, "_any"},      64'({any_w, any_s}), 64'd0);
  endtask

  // Inputs change only at negedge; the model advances with the inputs the
  // DUT sees on the following posedge, and outputs are sampled at negedge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- table-driven directed vectors ----------------
  typedef struct {
    int          ch;
    bit          en, dir, clr, load, oc;
    logic [15:0] lv, tv;
    logic [15:0] c0;  bit t0, o0;   // expected, wrap instance
    logic [15:0] c1;  bit t1, o1;   // expected, saturate instance
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int ch, bit e, bit d, bit c, bit l, bit oc,
                              int lv, int tv, int c0, bit t0, bit o0,
                              int c1, bit t1, bit o1);
    vec_t v;
    v.ch = ch; v.en = e; v.dir = d; v.clr = c; v.load = l; v.oc = oc;
    v.lv = 16'(lv); v.tv = 16'(tv);
    v.c0 = 16'(c0); v.t0 = t0; v.o0 = o0;
    v.c1 = 16'(c1); v.t1 = t1; v.o1 = o1;
    return v;
  endfunction

  initial begin
    logic [15:0] a0, a1;
    rst_n = 1'b0; en = '1; dir = '1; clr = '0; load = '0;
    load_val = '0; term_val = '0; ovf_clr = 1'b0;
    model_reset();

    // Up wrap/saturate on ch0, term 5
    for (int i = 1; i <= 5; i++) tbl.push_back(mk(0,1,1,0,0,0, 0,5, i,0,0, i,0,0));
    tbl.push_back(mk(0,1,1,0,0,0, 0,5, 0,1,1, 5,1,1));
    tbl.push_back(mk(0,1,1,0,0,0, 0,5, 1,0,1, 5,1,1));
    tbl.push_back(mk(0,1,1,0,0,0, 0,5, 2,0,1, 5,1,1));
    // Down on ch1 from 2, term 9
    tbl.push_back(mk(1,0,0,0,1,0, 2,9, 2,0,0, 2,0,0));
    tbl.push_back(mk(1,1,0,0,0,0, 2,9, 1,0,0, 1,0,0));
    tbl.push_back(mk(1,1,0,0,0,0, 2,9, 0,0,0, 0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0, 2,9, 9,1,1, 0,1,1));
    tbl.push_back(mk(1,1,0,0,0,0, 2,9, 8,0,1, 0,1,1));
    // Priority on ch2
    tbl.push_back(mk(2,0,1,0,1,0, 7,100, 7,0,0, 7,0,0));
    tbl.push_back(mk(2,1,1,1,1,0, 3,100, 0,0,0, 0,0,0));
    tbl.push_back(mk(2,0,1,0,1,0, 3,100, 3,0,0, 3,0,0));
    tbl.push_back(mk(2,1,1,0,0,0, 3,100, 4,0,0, 4,0,0));
    // Load above terminal on ch3, with ovf_clr colliding with the set
    tbl.push_back(mk(3,0,1,0,1,0, 200,10, 200,0,0, 200,0,0));
    tbl.push_back(mk(3,1,1,0,0,1, 200,10, 0,1,1, 200,1,1));
    tbl.push_back(mk(3,0,1,0,0,1, 200,10, 0,0,0, 200,0,0));

    // Reset held for 3 edges with everything enabled
    @(negedge clk);
    for (int i = 0; i < 3; i++) tick();
    $display("reset held 3 edges: cnt_w=%h cnt_s=%h", cnt_w, cnt_s);
    check_zero("reset_hold");

    // Release, idle for 5 edges
    rst_n = 1'b1; en = '0;
    for (int i = 0; i < 5; i++) tick();
    $display("idle 5 edges: cnt_w=%h cnt_s=%h", cnt_w, cnt_s);
    check_zero("idle");

    // Directed table
    foreach (tbl[i]) begin
      en = '0; dir = '0; clr = '0; load = '0;
      en[tbl[i].ch] = tbl[i].en; dir[tbl[i].ch] = tbl[i].dir;
      clr[tbl[i].ch] = tbl[i].clr; load[tbl[i].ch] = tbl[i].load;
      ovf_clr = tbl[i].oc;
      load_val = {N{tbl[i].lv}};
      term_val = {N{tbl[i].tv}};
      tick();
      a0 = cnt_w[tbl[i].ch*W +: W];
      a1 = cnt_s[tbl[i].ch*W +: W];
      $display("vec %0d ch%0d: wrap cnt=%0d tc=%b ovf=%b | sat cnt=%0d tc=%b ovf=%b",
               i, tbl[i].ch, a0, tc_w[tbl[i].ch], ovf_w[tbl[i].ch],
               a1, tc_s[tbl[i].ch], ovf_s[tbl[i].ch]);
      chk($sformatf("vec%0d_cnt_wrap", i), 64'(a0), 64'(tbl[i].c0));
      chk($sformatf("vec%0d_cnt_sat", i),  64'(a1), 64'(tbl[i].c1));
      chk($sformatf("vec%0d_tc_wrap", i),  64'(tc_w[tbl[i].ch]), 64'(tbl[i].t0));
      chk($sformatf("vec%0d_tc_sat", i),   64'(tc_s[tbl[i].ch]), 64'(tbl[i].t1));
      chk($sformatf("vec%0d_ovf_wrap", i), 64'(ovf_w[tbl[i].ch]), 64'(tbl[i].o0));
      chk($sformatf("vec%0d_ovf_sat", i),  64'(ovf_s[tbl[i].ch]), 64'(tbl[i].o1));
      chk($sformatf("vec%0d_any_wrap", i), 64'(any_w), 64'(tbl[i].t0));
      chk($sformatf("vec%0d_any_sat", i),  64'(any_s), 64'(tbl[i].t1));
    end

    // Randomised run against the reference model
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) begin
        en[k]   = ($urandom_range(0, 9) != 0);
        dir[k]  = ($urandom_range(0, 3) != 0);
        clr[k]  = ($urandom_range(0, 15) == 0);
        load[k] = ($urandom_range(0, 9) == 0);
        load_val[k*W +: W] = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 30));
        term_val[k*W +: W] = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 20));
      end
      ovf_clr = ($urandom_range(0, 7) == 0);
      tick();
      $display("rnd %0d: cnt_w=%h tc_w=%b cnt_s=%h tc_s=%b", i, cnt_w, tc_w, cnt_s, tc_s);
      check_model($sformatf("rnd%0d", i));
    end

    // Asynchronous reset between edges while all channels count up
    en = '1; dir = '1; clr = '0; load = '0; ovf_clr = 1'b0;
    term_val = {N{16'd3}};
    for (int i = 0; i < 6; i++) tick();
    @(posedge clk);
    model_step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    $display("async reset mid-run: cnt_w=%h cnt_s=%h any=%b%b", cnt_w, cnt_s, any_w, any_s);
    check_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      $display("post reset %0d: cnt_w=%h cnt_s=%h", i, cnt_w, cnt_s);
      check_model($sformatf("post%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/counter_cluster_param.md
Name: counter_cluster_param

Overview:
- Parametrised bank of N_CH independent up/down counters, WIDTH bits each, all on one clock.
- Successor to the fixed 8/12/16-bit counter clusters: every channel has enable, direction, synchronous clear, parallel load and a programmable terminal value, with wrap or saturate mode.
- Each channel raises a terminal-count pulse and a sticky overflow flag.
- Drives counter-bank and register-stress benchmarks; the flat count bus replicates straight onto wide output buses.

Parameters:
N_CH, 4, number of counter channels (>=1)
WIDTH, 16, bits per channel counter (>=2)
SAT_MODE, 0, 0 = wrap at terminal, 1 = saturate (hold) at terminal

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  asynchronous active-low reset; 0 clears all state immediately
en  input  N_CH  per-channel count enable
dir  input  N_CH  per-channel direction, 1 = up, 0 = down
clr  input  N_CH  per-channel synchronous clear
load  input  N_CH  per-channel synchronous parallel load
load_val  input  N_CH*WIDTH  load values, channel k at [k*WIDTH +: WIDTH]
term_val  input  N_CH*WIDTH  terminal values, same packing
ovf_clr  input  1  clears all sticky overflow flags
count  output  N_CH*WIDTH  registered counter values, same packing
tc  output  N_CH  registered one-cycle terminal-count pulse per channel
ovf  output  N_CH  sticky overflow flag per channel
any_tc  output  1  OR of tc, combinational from registered tc

Behaviour:
- Reset (reset=0, asynchronous): count=0, tc=0, ovf=0 for all channels; held while low.
- Reset release is synchronous in effect: the first update happens on the first rising edge with reset=1.
- Per-channel priority each edge: clr > load > en > hold.
  - clr: count<=0, tc<=0.
  - load: count<=load_val, tc<=0.
  - en=0: count holds, tc<=0.
- Up event (en=1, dir=1): terminal when count >= term_val.
  - Non-terminal: count<=count+1 modulo 2^WIDTH.
  - Terminal, SAT_MODE=0: count<=0.
  - Terminal, SAT_MODE=1: count holds.
  - tc<=1 on every terminal event.
- Down event (en=1, dir=0): terminal when count==0.
  - Non-terminal: count<=count-1.
  - Terminal, SAT_MODE=0: count<=term_val.
  - Terminal, SAT_MODE=1: count holds at 0.
  - tc<=1 on every terminal event.
- Latency: count and tc update on the same edge. tc is high for the cycle following the terminal edge.
- In saturate mode, tc stays high on every enabled cycle while the channel sits at terminal; it is not edge-detected.
- term_val=0, up: terminal every enabled cycle; count stays 0 and tc is continuous.
- Load above term_val, up: the next enabled edge is terminal (>= compare); wrap goes to 0.
- term_val all-ones, up, wrap: behaves as a plain modulo-2^WIDTH counter; tc fires at all-ones -> 0.
- Direction change takes effect on the next edge with no bubble.
- term_val is sampled combinationally every edge; changing it mid-count is legal and takes effect immediately.
- ovf[k] <= 1 when channel k has a terminal event. Otherwise ovf[k] <= 0 if ovf_clr=1.
- Terminal event and ovf_clr in the same cycle: set wins, ovf stays 1.
- clr and load do not affect ovf.
- Channels are fully independent; no shared state except ovf_clr.
- Reset asserted mid-count forces the reset values immediately, regardless of en/load/clr.

Test Plan:
- Reset then idle: hold reset=0 for 3 edges with en=all-1 -> count=0, tc=0, ovf=0; release, en=0 for 5 edges -> all outputs stay 0.
- Up wrap, WIDTH=16, SAT_MODE=0, ch0: term_val=5, en=1, dir=1 for 8 edges -> count 1,2,3,4,5,0,1,2; tc=1 only in the cycle count shows 0; ovf[0]=1 thereafter.
- Down wrap and saturate, ch1: load_val=2, then dir=0 for 4 edges, term_val=9 -> SAT_MODE=0: 1,0,9,8 with tc after the 0->9 edge; SAT_MODE=1: 1,0,0,0 with tc high on the last two cycles.
- Priority: ch2 count=7, same edge clr=1, load=1 (load_val=3), en=1 -> count=0; next edge clr=0, load=1 -> count=3; next edge load=0, en=1, up -> 4.
- Load above terminal: ch3 term_val=10, load 200, en up one edge -> count=0, tc=1; ovf_clr=1 on that same edge -> ovf[3]=1 (set wins); next edge with ovf_clr=1 and no event -> ovf[3]=0.
- Async reset mid-run: all channels counting, drive reset=0 between clock edges -> count/tc/ovf go to 0 before the next edge; any_tc=0.
